axi_user_arb: RTL and testbench
===============================

// Module: axi_user_arb
// PURPOSE
//   Two-master arbiter in front of the axi_rw user port. Master 0 is the
//   instruction-fetch line refill (read only). Master 1 is the data-cache line
//   refill/writeback (read or write). Picks one request, latches it, and holds
//   it on the user port until axi_rw signals completion. Returns rdata/resp
//   only to the requester that was granted.
// PARAMETERS
//   ADDR_W  64   address width of every addr port
//   DATA_W  512  line width of rdata/wdata ports
//   BLKS_W  8    burst-length field width (beats-1, as axi_rw user_blks_i)
// PORTS
//   clk          in   1       system clock
//   rst          in   1       asynchronous reset, active-low
//   m0_valid_i   in   1       ifetch request; held high until m0_ready_o
//   m0_ready_o   out  1       one-cycle done pulse; m0_rdata_o/m0_resp_o valid
//   m0_addr_i    in   ADDR_W  ifetch line address
//   m0_size_i    in   2       beat size code
//   m0_blks_i    in   BLKS_W  burst length
//   m0_rdata_o   out  DATA_W  returned line
//   m0_resp_o    out  2       AXI resp of the transaction
//   m1_valid_i   in   1       dcache request; held high until m1_ready_o
//   m1_ready_o   out  1       one-cycle done pulse for m1
//   m1_req_i     in   1       0 = read, 1 = write
//   m1_addr_i    in   ADDR_W  dcache line address
//   m1_size_i    in   2       beat size code
//   m1_blks_i    in   BLKS_W  burst length
//   m1_wdata_i   in   DATA_W  writeback line
//   m1_rdata_o   out  DATA_W  returned line
//   m1_resp_o    out  2       AXI resp
//   user_valid_o out  1       to axi_rw user_valid_i
//   user_ready_i in   1       from axi_rw user_ready_o, one-cycle done pulse
//   user_req_o   out  1       to axi_rw user_req_i (0 read, 1 write)
//   user_addr_o  out  ADDR_W  latched address
//   user_size_o  out  2       latched size
//   user_blks_o  out  BLKS_W  latched burst length
//   user_wdata_o out  DATA_W  latched write data
//   user_rdata_i in   DATA_W  from axi_rw user_rdata_o
//   user_resp_i  in   2       from axi_rw user_resp_o
//   m0_cnt_o     out  32      completed m0 transactions; wraps modulo 2^32
//   m1_cnt_o     out  32      completed m1 transactions; wraps modulo 2^32
// BEHAVIOUR
//   - FSM states: IDLE, GNT0, GNT1, DONE0, DONE1. All outputs are registered.
//   - Reset (rst=0, async): state=IDLE, last_gnt=1, all outputs and counters 0.
//   - IDLE, only one valid high: grant that master.
//   - IDLE, both valid high: grant the master != last_gnt (round robin).
//     After reset, m0 wins the first tie.
//   - On grant:
//     - latch addr/size/blks/req/wdata into user_* registers.
//     - m0 grant forces user_req_o=0 and user_wdata_o=0.
//     - set last_gnt; move to GNTx.
//     - user_valid_o=1 from the next cycle.
//   - GNTx: hold user_valid_o=1 with stable latched fields until user_ready_i=1.
//     Then: capture user_rdata_i/user_resp_i into mx_rdata_o/mx_resp_o,
//     drop user_valid_o, move to DONEx.
//   - DONEx (exactly 1 cycle): mx_ready_o=1, mx_cnt_o+=1, then go to IDLE.
//     Requester must drop valid in this cycle.
//   - mx_rdata_o/mx_resp_o hold their value until that master's next completion.
//   - Latency: valid at cycle N (IDLE) -> user_valid_o at N+1; user_ready_i at K
//     -> mx_ready_o at K+1 -> IDLE at K+2. Minimum 3 cycles per transaction.
//   - No grant is evaluated in DONEx, so a stale valid is never re-granted.
//   - user_ready_i outside GNTx: ignored, no state change.
//   - Requester drops valid during GNTx (protocol error): the transaction
//     completes on the latched fields and the done pulse is still issued.
//   - Non-granted master: its ready stays 0 and its valid is only sampled in IDLE.
//   - Reset mid-transaction: immediate return to IDLE, nothing is retried.
//     axi_rw shares the same reset.
// TESTING
//   - Lone m0 read, addr 0x8000_0000, blks 7; axi_rw ready 5 cycles after
//     valid -> user_req_o=0, m0_ready_o single pulse, m0_rdata_o=line,
//     m0_cnt_o=1.
//   - m0 and m1 valid in the same cycle after reset -> m0 served first.
//     Next tie -> m1 served. Third tie -> m0 served.
//   - m1 write, addr 0x8000_0040, wdata pattern, strobed resp 2'b00 ->
//     user_req_o=1, user_wdata_o matches for the whole grant,
//     m1_resp_o=0, m0_ready_o never pulses.
//   - Spurious user_ready_i in IDLE, and m1 dropping valid mid-grant ->
//     no state change in IDLE; the grant completes with one m1_ready_o pulse.
//   - Assert rst low during GNT1 -> next edge: IDLE, user_valid_o=0, counters 0;
//     a new m0 request is then granted normally.
//   - Preload m0_cnt to 0xFFFF_FFFF via 2^32-1 forced completions (or force)
//     -> next completion wraps it to 0.

Source files
------------

// File: rtl/axi_user_arb.sv
// axi_user_arb: two-master round-robin arbiter that latches one request and holds it on the axi_rw user port until done.
module axi_user_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int BLKS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid_i,
  output logic              m0_ready_o,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [1:0]        m0_size_i,
  input  logic [BLKS_W-1:0] m0_blks_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic [1:0]        m0_resp_o,
  input  logic              m1_valid_i,
  output logic              m1_ready_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [1:0]        m1_size_i,
  input  logic [BLKS_W-1:0] m1_blks_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [1:0]        m1_resp_o,
  output logic              user_valid_o,
  input  logic              user_ready_i,
  output logic              user_req_o,
  output logic [ADDR_W-1:0] user_addr_o,
  output logic [1:0]        user_size_o,
  output logic [BLKS_W-1:0] user_blks_o,
  output logic [DATA_W-1:0] user_wdata_o,
  input  logic [DATA_W-1:0] user_rdata_i,
  input  logic [1:0]        user_resp_i,
  output logic [31:0]       m0_cnt_o,
  output logic [31:0]       m1_cnt_o
);
  typedef enum logic [2:0] {IDLE, GNT0, GNT1, DONE0, DONE1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic valid_q, valid_d, req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0] size_q, size_d, m0_resp_q, m0_resp_d, m1_resp_q, m1_resp_d;
  logic [BLKS_W-1:0] blks_q, blks_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
  logic [31:0] m0_cnt_q, m0_cnt_d, m1_cnt_q, m1_cnt_d;
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    valid_d    = valid_q;
    req_d      = req_q;
    addr_d     = addr_q;
    size_d     = size_q;
    blks_d     = blks_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m0_resp_d  = m0_resp_q;
    m1_rdata_d = m1_rdata_q;
    m1_resp_d  = m1_resp_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_cnt_d   = m0_cnt_q;
    m1_cnt_d   = m1_cnt_q;
    case (state_q)
      IDLE: begin
        // On a tie, m0 wins only when m1 had the previous grant
        if (m0_valid_i && (!m1_valid_i || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
          valid_d = 1'b1;
          req_d   = 1'b0;
          addr_d  = m0_addr_i;
          size_d  = m0_size_i;
          blks_d  = m0_blks_i;
          wdata_d = '0;
        end else if (m1_valid_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
          valid_d = 1'b1;
          req_d   = m1_req_i;
          addr_d  = m1_addr_i;
          size_d  = m1_size_i;
          blks_d  = m1_blks_i;
          wdata_d = m1_wdata_i;
        end
      end
      GNT0: if (user_ready_i) begin
        state_d    = DONE0;
        valid_d    = 1'b0;
        m0_rdata_d = user_rdata_i;
        m0_resp_d  = user_resp_i;
        m0_ready_d = 1'b1;
        m0_cnt_d   = m0_cnt_q + 32'd1;
      end
      GNT1: if (user_ready_i) begin
        state_d    = DONE1;
        valid_d    = 1'b0;
        m1_rdata_d = user_rdata_i;
        m1_resp_d  = user_resp_i;
        m1_ready_d = 1'b1;
        m1_cnt_d   = m1_cnt_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      blks_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m0_resp_q  <= '0;
      m1_rdata_q <= '0;
      m1_resp_q  <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_cnt_q   <= '0;
      m1_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      blks_q     <= blks_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m0_resp_q  <= m0_resp_d;
      m1_rdata_q <= m1_rdata_d;
      m1_resp_q  <= m1_resp_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_cnt_q   <= m0_cnt_d;
      m1_cnt_q   <= m1_cnt_d;
    end
  end
  assign user_valid_o = valid_q;
  assign user_req_o   = req_q;
  assign user_addr_o  = addr_q;
  assign user_size_o  = size_q;
  assign user_blks_o  = blks_q;
  assign user_wdata_o = wdata_q;
  assign m0_rdata_o   = m0_rdata_q;
  assign m0_resp_o    = m0_resp_q;
  assign m1_rdata_o   = m1_rdata_q;
  assign m1_resp_o    = m1_resp_q;
  assign m0_ready_o   = m0_ready_q;
  assign m1_ready_o   = m1_ready_q;
  assign m0_cnt_o     = m0_cnt_q;
  assign m1_cnt_o     = m1_cnt_q;
endmodule

// File: tb/tb_axi_user_arb.sv
// tb_axi_user_arb: directed self-checking bench for the two-master user-port arbiter.
module tb_axi_user_arb;
  localparam int AW = 64, DW = 512, BW = 8;
  logic clk = 1'b0, rst = 1'b0;
  logic m0_valid_i = 0, m0_ready_o;
  logic [AW-1:0] m0_addr_i = '0;
  logic [1:0] m0_size_i = '0, m0_resp_o;
  logic [BW-1:0] m0_blks_i = '0;
  logic [DW-1:0] m0_rdata_o;
  logic m1_valid_i = 0, m1_ready_o, m1_req_i = 0;
  logic [AW-1:0] m1_addr_i = '0;
  logic [1:0] m1_size_i = '0, m1_resp_o;
  logic [BW-1:0] m1_blks_i = '0;
  logic [DW-1:0] m1_wdata_i = '0, m1_rdata_o;
  logic user_valid_o, user_ready_i = 0, user_req_o;
  logic [AW-1:0] user_addr_o;
  logic [1:0] user_size_o, user_resp_i = '0;
  logic [BW-1:0] user_blks_o;
  logic [DW-1:0] user_wdata_o, user_rdata_i = '0;
  logic [31:0] m0_cnt_o, m1_cnt_o;
  int n_cmp = 0, n_bad = 0, p0 = 0, p1 = 0;
  logic [DW-1:0] line_a, line_b, wpat;

  axi_user_arb #(.ADDR_W(AW), .DATA_W(DW), .BLKS_W(BW)) dut (
    .clk(clk), .rst(rst),
    .m0_valid_i(m0_valid_i), .m0_ready_o(m0_ready_o), .m0_addr_i(m0_addr_i),
    .m0_size_i(m0_size_i), .m0_blks_i(m0_blks_i), .m0_rdata_o(m0_rdata_o), .m0_resp_o(m0_resp_o),
    .m1_valid_i(m1_valid_i), .m1_ready_o(m1_ready_o), .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i),
    .m1_size_i(m1_size_i), .m1_blks_i(m1_blks_i), .m1_wdata_i(m1_wdata_i),
    .m1_rdata_o(m1_rdata_o), .m1_resp_o(m1_resp_o),
    .user_valid_o(user_valid_o), .user_ready_i(user_ready_i), .user_req_o(user_req_o),
    .user_addr_o(user_addr_o), .user_size_o(user_size_o), .user_blks_o(user_blks_o),
    .user_wdata_o(user_wdata_o), .user_rdata_i(user_rdata_i), .user_resp_i(user_resp_i),
    .m0_cnt_o(m0_cnt_o), .m1_cnt_o(m1_cnt_o)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (m0_ready_o) p0++;
    if (m1_ready_o) p1++;
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!user_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, DW'(user_valid_o), DW'(1));
  endtask

  // Completes the current grant after dly idle cycles; returns in the DONE cycle
  task automatic pulse(input int dly, input logic [DW-1:0] d, input logic [1:0] r);
    repeat (dly) @(negedge clk);
    user_ready_i = 1'b1;
    user_rdata_i = d;
    user_resp_i  = r;
    @(negedge clk);
    user_ready_i = 1'b0;
  endtask

  task automatic tie(input string tag, input bit exp_m1);
    m0_valid_i = 1'b1;
    m1_valid_i = 1'b1;
    m1_req_i   = 1'b0;
    @(negedge clk);
    chk({tag, "_addr"}, DW'(user_addr_o), exp_m1 ? DW'(m1_addr_i) : DW'(m0_addr_i));
    wait_valid({tag, "_valid"});
    pulse(1, line_a, 2'b01);
    chk({tag, "_r0"}, DW'(m0_ready_o), DW'(!exp_m1));
    chk({tag, "_r1"}, DW'(m1_ready_o), DW'(exp_m1));
    m0_valid_i = 1'b0;
    m1_valid_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    line_a = {8{64'h0123_4567_89AB_CDEF}};
    line_b = {16{32'hCAFE_0000}} ^ {DW{1'b1}};
    wpat   = {8{64'hDEAD_BEEF_5A5A_A5A5}};
    m0_addr_i = 64'h1000;
    m1_addr_i = 64'h2000;
    repeat (2) @(negedge clk);
    chk("rst_uvalid", DW'(user_valid_o), DW'(0));
    chk("rst_cnt0", DW'(m0_cnt_o), DW'(0));
    chk("rst_cnt1", DW'(m1_cnt_o), DW'(0));
    chk("rst_rdata0", m0_rdata_o, '0);
    rst = 1'b1;
    @(negedge clk);
    tie("tie1_m0", 1'b0);
    tie("tie2_m1", 1'b1);
    tie("tie3_m0", 1'b0);
    chk("tie_cnt0", DW'(m0_cnt_o), DW'(2));
    chk("tie_cnt1", DW'(m1_cnt_o), DW'(1));

    p0 = 0;
    m0_addr_i = 64'h8000_0000;
    m0_blks_i = 8'd7;
    m0_size_i = 2'd3;
    m0_valid_i = 1'b1;
    @(negedge clk);
    chk("m0_uvalid_n1", DW'(user_valid_o), DW'(1));
    chk("m0_req", DW'(user_req_o), DW'(0));
    chk("m0_addr", DW'(user_addr_o), DW'(64'h8000_0000));
    chk("m0_blks", DW'(user_blks_o), DW'(7));
    chk("m0_wdata", user_wdata_o, '0);
    pulse(4, line_b, 2'b00);
    chk("m0_ready", DW'(m0_ready_o), DW'(1));
    chk("m0_rdata", m0_rdata_o, line_b);
    chk("m0_cnt", DW'(m0_cnt_o), DW'(3));
    chk("m0_uvalid_drop", DW'(user_valid_o), DW'(0));
    m0_valid_i = 1'b0;
    @(negedge clk);
    chk("m0_ready_low", DW'(m0_ready_o), DW'(0));
    chk("m0_pulses", DW'(p0), DW'(1));

    p0 = 0;
    p1 = 0;
    m1_addr_i  = 64'h8000_0040;
    m1_req_i   = 1'b1;
    m1_wdata_i = wpat;
    m1_valid_i = 1'b1;
    @(negedge clk);
    wait_valid("m1w_valid");
    for (int i = 0; i < 3; i++) begin
      chk("m1w_req", DW'(user_req_o), DW'(1));
      chk("m1w_wdata", user_wdata_o, wpat);
      chk("m1w_addr", DW'(user_addr_o), DW'(64'h8000_0040));
      @(negedge clk);
    end
    pulse(0, line_a, 2'b00);
    chk("m1w_ready", DW'(m1_ready_o), DW'(1));
    chk("m1w_resp", DW'(m1_resp_o), DW'(0));
    chk("m1w_cnt", DW'(m1_cnt_o), DW'(2));
    m1_valid_i = 1'b0;
    m1_req_i   = 1'b0;
    repeat (2) @(negedge clk);
    chk("m1w_no_m0", DW'(p0), DW'(0));
    chk("m0_rdata_hold", m0_rdata_o, line_b);

    p1 = 0;
    user_ready_i = 1'b1;
    @(negedge clk);
    user_ready_i = 1'b0;
    @(negedge clk);
    chk("spur_uvalid", DW'(user_valid_o), DW'(0));
    chk("spur_r1", DW'(p1), DW'(0));
    chk("spur_cnt1", DW'(m1_cnt_o), DW'(2));
    m1_valid_i = 1'b1;
    @(negedge clk);
    wait_valid("drop_valid");
    m1_valid_i = 1'b0;
    @(negedge clk);
    chk("drop_hold", DW'(user_valid_o), DW'(1));
    pulse(1, line_b, 2'b10);
    chk("drop_ready", DW'(m1_ready_o), DW'(1));
    chk("drop_resp", DW'(m1_resp_o), DW'(2));
    @(negedge clk);
    chk("drop_pulses", DW'(p1), DW'(1));
    chk("drop_cnt1", DW'(m1_cnt_o), DW'(3));

    m1_valid_i = 1'b1;
    @(negedge clk);
    wait_valid("rst_gnt1_valid");
    rst = 1'b0;
    #1;
    chk("rst_mid_uvalid", DW'(user_valid_o), DW'(0));
    chk("rst_mid_cnt0", DW'(m0_cnt_o), DW'(0));
    chk("rst_mid_cnt1", DW'(m1_cnt_o), DW'(0));
    m1_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_idle", DW'(user_valid_o), DW'(0));
    m0_valid_i = 1'b1;
    @(negedge clk);
    wait_valid("post_rst_valid");
    chk("post_rst_req", DW'(user_req_o), DW'(0));
    pulse(2, line_a, 2'b00);
    chk("post_rst_ready", DW'(m0_ready_o), DW'(1));
    chk("post_rst_cnt0", DW'(m0_cnt_o), DW'(1));
    m0_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    force dut.m0_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.m0_cnt_q;
    @(negedge clk);
    chk("wrap_pre", DW'(m0_cnt_o), DW'(32'hFFFF_FFFF));
    m0_valid_i = 1'b1;
    @(negedge clk);
    wait_valid("wrap_valid");
    pulse(1, line_b, 2'b00);
    chk("wrap_cnt0", DW'(m0_cnt_o), DW'(0));
    m0_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
